// File: rtl/wb_bram_slave.sv
// Wishbone BRAM slave for the 0x380xxxxx window; every access waits DELAYS cycles before the ack.
// Define WB_BRAM_BOUND_EN to drop writes and zero reads that fall beyond the memory depth.
module wb_bram_slave #(
   parameter int ADDR_W = 10,
   parameter int DELAYS = 10
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   state_t            state, state_nxt;
   logic [7:0]        cnt;
   logic [ADDR_W-1:0] lat_idx;
   logic              lat_we;
   logic [3:0]        lat_sel;
   logic [31:0]       lat_dat;
   logic              lat_inr;
   logic              hit;
   logic              access;
   logic              unused_adr;

   logic [31:0]       mem [DEPTH];

   assign hit        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:20] == 12'h380);
   assign access     = (state == WAIT) && wbs_cyc_i && (cnt == 8'(DELAYS - 1));
   assign unused_adr = &{1'b0, wbs_adr_i[1:0], wbs_adr_i[19:ADDR_W+2]};

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) state <= IDLE;
      else          state <= state_nxt;
   end

   // NOTE: next state takes its default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (hit) state_nxt = WAIT;
         WAIT:    if (!wbs_cyc_i) state_nxt = IDLE;
                  else if (cnt == 8'(DELAYS - 1)) state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: registers update with <= so every read in this edge sees pre-edge values.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         cnt       <= '0;
         lat_idx   <= '0;
         lat_we    <= 1'b0;
         lat_sel   <= '0;
         lat_dat   <= '0;
         lat_inr   <= 1'b0;
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
      end else begin
         wbs_ack_o <= access;
         if (state == IDLE && hit) begin
            cnt     <= '0;
            lat_idx <= wbs_adr_i[ADDR_W+1:2];
            lat_we  <= wbs_we_i;
            lat_sel <= wbs_sel_i;
            lat_dat <= wbs_dat_i;
`ifdef WB_BRAM_BOUND_EN
            lat_inr <= (32'(wbs_adr_i[19:0]) < 32'(DEPTH * 4));
`else
            lat_inr <= 1'b1;
`endif
         end else if (state == WAIT && wbs_cyc_i) begin
            cnt <= cnt + 8'd1;
         end
         // Read data is visible only during the ACK cycle and is zero otherwise.
         if (access && !lat_we) wbs_dat_o <= lat_inr ? mem[lat_idx] : 32'h0;
         else if (state == ACK) wbs_dat_o <= '0;
      end
   end

   // NOTE: the memory array has no reset; contents survive wb_rst_i like a real BRAM.
   always_ff @(posedge wb_clk_i) begin
      if (access && lat_we && lat_inr) begin
         for (int b = 0; b < 4; b++) begin
            if (lat_sel[b]) mem[lat_idx][8*b +: 8] <= lat_dat[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_wb_bram_slave.sv
// Directed bench for wb_bram_slave: a DELAYS=10 instance and a DELAYS=1 instance, scoreboarded reads.
module tb_wb_bram_slave;

   localparam int D0 = 10;
   localparam int D1 = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc [2];
   logic        stb [2];
   logic        we  [2];
   logic [3:0]  sel [2];
   logic [31:0] adr [2];
   logic [31:0] wdat[2];
   logic        ack [2];
   logic [31:0] rdat[2];

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] sb [$];
   logic [31:0] model [int];

   always #5 clk = ~clk;

   wb_bram_slave #(.ADDR_W(10), .DELAYS(D0)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we[0]), .wbs_sel_i(sel[0]),
      .wbs_adr_i(adr[0]), .wbs_dat_i(wdat[0]), .wbs_ack_o(ack[0]), .wbs_dat_o(rdat[0])
   );

   wb_bram_slave #(.ADDR_W(10), .DELAYS(D1)) dut1 (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we[1]), .wbs_sel_i(sel[1]),
      .wbs_adr_i(adr[1]), .wbs_dat_i(wdat[1]), .wbs_ack_o(ack[1]), .wbs_dat_o(rdat[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference memory for the DELAYS=10 instance; returns what wbs_dat_o must carry at the ack.
   function automatic logic [31:0] model_access(input logic w, input logic [31:0] a,
                                                input logic [3:0] s, input logic [31:0] d);
      int idx = int'(a[11:2]);
      bit inr = 1'b1;
`ifdef WB_BRAM_BOUND_EN
      inr = (a[19:0] < 20'd4096);
`endif
      if (!model.exists(idx)) model[idx] = 'x;
      if (w) begin
         if (inr) for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
         return 32'h0;
      end
      return inr ? model[idx] : 32'h0;
   endfunction

   task automatic idle_bus(input int d);
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      sel[d] = 4'h0; adr[d] = 32'h0; wdat[d] = 32'h0;
   endtask

   task automatic drive(input int d, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] v);
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s; adr[d] = a; wdat[d] = v;
   endtask

   // One complete transfer, started and finished on a falling edge.
   task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] v, input logic [31:0] exp, input string tag);
      int  lat = 0;
      bit  got = 1'b0;
      logic [31:0] e;
      sb.push_back(exp);
      drive(d, w, a, s, v);
      while (!got && lat < 40) begin
         @(negedge clk);
         lat++;
         if (ack[d]) got = 1'b1;
      end
      check({tag, " latency"}, 32'(lat), 32'(d == 0 ? D0 + 1 : D1 + 1));
      e = sb.pop_front();
      if (got) check({tag, " data"}, rdat[d], e);
      // Change inputs mid-ack; the latched request must not be re-used.
      adr[d] = 32'h0; wdat[d] = 32'hDEAD_BEEF;
      idle_bus(d);
      @(negedge clk);
      check({tag, " ack width"}, 32'(ack[d]), 32'h0);
      check({tag, " dat cleared"}, rdat[d], 32'h0);
   endtask

   task automatic count_acks(input int d, input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (ack[d]) n++;
      end
   endtask

   initial begin
      int n;
      logic [31:0] e;
      idle_bus(0);
      idle_bus(1);
      #1;
      check("reset ack", 32'(ack[0]), 32'h0);
      check("reset dat", rdat[0], 32'h0);
      check("reset ack d1", 32'(ack[1]), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Full write, then read-back.
      xfer(0, 1'b1, 32'h3800_0010, 4'hF, 32'hCAFE_1234,
           model_access(1'b1, 32'h3800_0010, 4'hF, 32'hCAFE_1234), "wr10");
      xfer(0, 1'b0, 32'h3800_0010, 4'h0, 32'h0,
           model_access(1'b0, 32'h3800_0010, 4'h0, 32'h0), "rd10");

      // Byte lanes.
      xfer(0, 1'b1, 32'h3800_0020, 4'hF, 32'h1122_3344,
           model_access(1'b1, 32'h3800_0020, 4'hF, 32'h1122_3344), "pre20");
      xfer(0, 1'b1, 32'h3800_0020, 4'b0101, 32'hAABB_CCDD,
           model_access(1'b1, 32'h3800_0020, 4'b0101, 32'hAABB_CCDD), "lane20");
      xfer(0, 1'b0, 32'h3800_0020, 4'h0, 32'h0, 32'h11BB_33DD, "rdlane");
      // sel=0 write is acked but leaves memory alone; low address bits are ignored.
      xfer(0, 1'b1, 32'h3800_0020, 4'h0, 32'hFFFF_FFFF,
           model_access(1'b1, 32'h3800_0020, 4'h0, 32'hFFFF_FFFF), "sel0");
      xfer(0, 1'b0, 32'h3800_0023, 4'h0, 32'h0,
           model_access(1'b0, 32'h3800_0023, 4'h0, 32'h0), "rdsel0");

      // Foreign window: never acked, and the slave remains ready afterwards.
      drive(0, 1'b0, 32'h3000_0000, 4'hF, 32'h0);
      count_acks(0, 20, n);
      check("uart acks", 32'(n), 32'h0);
      idle_bus(0);
      @(negedge clk);
      xfer(0, 1'b0, 32'h3800_0010, 4'h0, 32'h0, 32'hCAFE_1234, "post_uart");

      // Aborted write: cyc drops after 4 cycles.
      drive(0, 1'b1, 32'h3800_0010, 4'hF, 32'h0BAD_0BAD);
      count_acks(0, 4, n);
      idle_bus(0);
      count_acks(0, 16, e);
      check("abort acks", 32'(n) + e, 32'h0);
      xfer(0, 1'b0, 32'h3800_0010, 4'h0, 32'h0,
           model_access(1'b0, 32'h3800_0010, 4'h0, 32'h0), "rd_abort");

      // Bounds / aliasing.
      xfer(0, 1'b1, 32'h3800_0000, 4'hF, 32'h0BAD_F00D,
           model_access(1'b1, 32'h3800_0000, 4'hF, 32'h0BAD_F00D), "pre0");
      xfer(0, 1'b1, 32'h3800_1000, 4'hF, 32'h5555_5555,
           model_access(1'b1, 32'h3800_1000, 4'hF, 32'h5555_5555), "wr1000");
`ifdef WB_BRAM_BOUND_EN
      xfer(0, 1'b0, 32'h3800_0000, 4'h0, 32'h0, 32'h0BAD_F00D, "rd0");
      xfer(0, 1'b0, 32'h3800_1000, 4'h0, 32'h0, 32'h0000_0000, "rd1000");
`else
      xfer(0, 1'b0, 32'h3800_0000, 4'h0, 32'h0, 32'h5555_5555, "rd0");
      xfer(0, 1'b0, 32'h3800_1000, 4'h0, 32'h0, 32'h5555_5555, "rd1000");
`endif
      void'(model_access(1'b0, 32'h3800_0000, 4'h0, 32'h0));

      // Reset in the middle of a write's wait.
      drive(0, 1'b1, 32'h3800_0020, 4'hF, 32'h7777_7777);
      count_acks(0, 5, n);
      rst = 1'b1;
      idle_bus(0);
      @(negedge clk);
      check("rst ack", 32'(ack[0]), 32'h0);
      rst = 1'b0;
      count_acks(0, 15, e);
      check("rst acks", 32'(n) + e, 32'h0);
      xfer(0, 1'b0, 32'h3800_0020, 4'h0, 32'h0,
           model_access(1'b0, 32'h3800_0020, 4'h0, 32'h0), "rd_rst");

      // DELAYS=1: two-cycle ack, and back-to-back reads under a held strobe.
      xfer(1, 1'b1, 32'h3800_0040, 4'hF, 32'h600D_F00D, 32'h0, "d1wr");
      sb.push_back(32'h600D_F00D);
      sb.push_back(32'h600D_F00D);
      drive(1, 1'b0, 32'h3800_0040, 4'h0, 32'h0);
      n = 0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         check($sformatf("b2b ack c%0d", i), 32'(ack[1]), 32'((i == 2) || (i == 5)));
         if (ack[1]) begin
            n++;
            e = sb.pop_front();
            check($sformatf("b2b dat c%0d", i), rdat[1], e);
         end
      end
      idle_bus(1);
      check("b2b count", 32'(n), 32'h2);
      @(negedge clk);
      check("b2b tail", 32'(ack[1]), 32'h0);
      check("sb empty", 32'(sb.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
